// File: rtl/usb_crc_gen_pkg.sv
// Shared constants and types for the USB serial CRC appender.
package usb_crc_gen_pkg;

  localparam int unsigned CRC5_W  = 5;
  localparam int unsigned CRC16_W = 16;
  localparam int unsigned CNT_W   = 4;

  localparam logic [CRC5_W-1:0]  POLY5   = 5'b00101;
  localparam logic [CRC16_W-1:0] POLY16  = 16'h8005;
  localparam logic [CRC5_W-1:0]  INIT5   = 5'h1F;
  localparam logic [CRC16_W-1:0] INIT16  = 16'hFFFF;
  localparam logic [CRC5_W-1:0]  RESID5  = 5'b01100;
  localparam logic [CRC16_W-1:0] RESID16 = 16'h800D;

  typedef enum logic [1:0] {
    PKT_NONE      = 2'b00,
    PKT_TOKEN     = 2'b01,
    PKT_DATA      = 2'b10,
    PKT_HANDSHAKE = 2'b11
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    SEND5  = 2'b10,
    SEND16 = 2'b11
  } crc_state_t;

endpackage

// File: rtl/usb_crc_gen_if.sv
// Serial TX stream between packet serializer, CRC appender and bit-stuffer.
interface usb_crc_gen_if;

  logic [1:0] pkt_in;
  logic       s_in;
  logic       endr;
  logic       pause;
  logic       s_out;
  logic       start_b;
  logic       endb;

  modport master (
    output pkt_in, s_in, endr, pause,
    input  s_out, start_b, endb
  );

  modport slave (
    input  pkt_in, s_in, endr, pause,
    output s_out, start_b, endb
  );

endinterface

// File: rtl/usb_crc_gen_lfsr.sv
// Serial MSB-first CRC LFSR with init/shift/hold; rst_n is synchronous active-high.
module usb_crc_gen_lfsr #(
  parameter int unsigned     W    = 5,
  parameter logic [W-1:0]    POLY = '0,
  parameter logic [W-1:0]    INIT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] crc
);

  logic fb;

  assign fb = din ^ crc[W-1];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      crc <= INIT;
    end else if (init) begin
      crc <= INIT;
    end else if (shift) begin
      crc <= {crc[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/usb_crc_gen.sv
// USB TX CRC appender: passes raw bits through, then appends ~CRC5/~CRC16 MSB first.
// rst_n is a synchronous, active-high reset (name inherited from the codebase).
module usb_crc_gen
  import usb_crc_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  usb_crc_gen_if.slave  bus
);

  crc_state_t           crc_cs;
  pkt_t                 pkt_q;
  logic [CRC16_W-1:0]   out_sr;
  logic [CNT_W-1:0]     bits_left;
  logic [CRC5_W-1:0]    crc5;
  logic [CRC16_W-1:0]   crc16;
  logic                 crc_init;
  logic                 crc_shift;
  logic                 crc5_done;
  logic                 crc16_done;
  logic                 empty;
  logic                 sending;
  logic                 s_out_q;
  logic                 start_b_q;
  logic                 endb_q;

  assign crc5_done  = (crc_cs == SEND5);
  assign crc16_done = (crc_cs == SEND16);
  assign empty      = (bits_left == '0);
  assign sending    = crc5_done | crc16_done;

  // Both LFSRs track every packet; the latched type picks which one is appended.
  assign crc_init  = !bus.pause && (crc_cs == IDLE) && (bus.pkt_in != 2'b00);
  assign crc_shift = !bus.pause && (crc_cs == DATA) && !bus.endr;

  usb_crc_gen_lfsr #(.W(CRC5_W), .POLY(POLY5), .INIT(INIT5)) u_crc5 (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .shift (crc_shift),
    .din   (bus.s_in),
    .crc   (crc5)
  );

  usb_crc_gen_lfsr #(.W(CRC16_W), .POLY(POLY16), .INIT(INIT16)) u_crc16 (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .shift (crc_shift),
    .din   (bus.s_in),
    .crc   (crc16)
  );

  always_ff @(posedge clk) begin : ctrl
    if (rst_n) begin
      crc_cs    <= IDLE;
      pkt_q     <= PKT_NONE;
      out_sr    <= '0;
      bits_left <= '0;
      s_out_q   <= 1'b0;
      start_b_q <= 1'b0;
      endb_q    <= 1'b0;
    end else if (!bus.pause) begin
      unique case (crc_cs)
        IDLE: begin
          endb_q <= 1'b0;
          if (bus.pkt_in != 2'b00) begin
            pkt_q  <= pkt_t'(bus.pkt_in);
            crc_cs <= DATA;
          end
        end
        DATA: begin
          if (bus.endr) begin
            // First CRC bit goes out on the endr edge so the stream has no gap.
            unique case (pkt_q)
              PKT_TOKEN: begin
                s_out_q   <= ~crc5[CRC5_W-1];
                out_sr    <= {~crc5[CRC5_W-2:0], (CRC16_W-CRC5_W+1)'(0)};
                bits_left <= CNT_W'(CRC5_W - 1);
                start_b_q <= 1'b1;
                crc_cs    <= SEND5;
              end
              PKT_DATA: begin
                s_out_q   <= ~crc16[CRC16_W-1];
                out_sr    <= {~crc16[CRC16_W-2:0], 1'b0};
                bits_left <= CNT_W'(CRC16_W - 1);
                start_b_q <= 1'b1;
                crc_cs    <= SEND16;
              end
              default: begin
                s_out_q   <= 1'b0;
                start_b_q <= 1'b0;
                endb_q    <= 1'b1;
                crc_cs    <= IDLE;
              end
            endcase
          end else begin
            s_out_q   <= bus.s_in;
            start_b_q <= 1'b1;
          end
        end
        default: begin
          if (sending && !empty) begin
            s_out_q   <= out_sr[CRC16_W-1];
            out_sr    <= {out_sr[CRC16_W-2:0], 1'b0};
            bits_left <= bits_left - CNT_W'(1);
            endb_q    <= (bits_left == CNT_W'(1));
          end else begin
            s_out_q   <= 1'b0;
            start_b_q <= 1'b0;
            endb_q    <= 1'b0;
            crc_cs    <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.s_out   = s_out_q;
  assign bus.start_b = start_b_q;
  assign bus.endb    = endb_q;

endmodule

// File: tb/tb_usb_crc_gen.sv
// Scoreboard bench for usb_crc_gen: CRC expectations come from polynomial long division.
module tb_usb_crc_gen;
  import usb_crc_gen_pkg::*;

  typedef struct {
    bit b;
    bit last;
    bit hs;
  } exp_t;

  logic clk;
  logic rst_n;
  usb_crc_gen_if bus ();

  usb_crc_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [1:0] typ_q[$];
  bit   act_bits[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Remainder of (msg * x^w + all-ones * x^len) divided by generator g (degree w).
  function automatic logic [15:0] poly_rem(input bit msg[$], input int w, input logic [16:0] g);
    bit a[$];
    logic [15:0] r;
    a = msg;
    for (int i = 0; i < w; i++) a.push_back(1'b0);
    for (int i = 0; i < w; i++) a[i] = a[i] ^ 1'b1;
    for (int i = 0; i < msg.size(); i++)
      if (a[i])
        for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ g[w-j];
    r = '0;
    for (int j = 0; j < w; j++) r[w-1-j] = a[msg.size()+j];
    return r;
  endfunction

  localparam logic [16:0] G5  = 17'b00000000000_100101;
  localparam logic [16:0] G16 = 17'h18005;

  task automatic tick(input bit p);
    bus.pause = p;
    @(posedge clk);
    #1;
  endtask

  // np paused cycles with junk inputs, then one live cycle with the given inputs.
  task automatic step(input int np, input bit sin, input bit er, input logic [1:0] pk);
    for (int i = 0; i < np; i++) begin
      bus.s_in   = 1'($urandom);
      bus.endr   = 1'($urandom);
      bus.pkt_in = 2'($urandom);
      tick(1'b1);
    end
    bus.s_in   = sin;
    bus.endr   = er;
    bus.pkt_in = pk;
    tick(1'b0);
  endtask

  function automatic int rnd_pause(input bit rnd);
    if (!rnd) return 0;
    return ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic send_pkt(input logic [1:0] typ, input bit bits[$], input int pz_data,
                          input int pz_crc, input bit rnd, input int abort_k);
    int w;
    logic [15:0] rem;
    exp_t e;
    w = (typ == PKT_TOKEN) ? 5 : 16;
    rem = (typ == PKT_TOKEN) ? poly_rem(bits, 5, G5) : poly_rem(bits, 16, G16);
    for (int i = 0; i < bits.size(); i++) begin
      e.b = bits[i]; e.last = 1'b0; e.hs = 1'b0;
      exp_q.push_back(e);
    end
    if (typ == PKT_HANDSHAKE) begin
      e.b = 1'b0; e.last = 1'b0; e.hs = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int k = w - 1; k >= 0; k--) begin
        e.b = ~rem[k]; e.last = (k == 0); e.hs = 1'b0;
        exp_q.push_back(e);
      end
    end
    typ_q.push_back(typ);

    step(rnd_pause(rnd), 1'($urandom), 1'b0, typ);
    for (int i = 0; i < bits.size(); i++)
      step((i == pz_data) ? 3 : rnd_pause(rnd), bits[i], 1'b0, 2'($urandom));
    step(rnd_pause(rnd), 1'($urandom), 1'b1, 2'($urandom));
    if (typ != PKT_HANDSHAKE) begin
      for (int k = 0; k < w; k++) begin
        if (k == abort_k) break;
        step((k == pz_crc) ? 3 : rnd_pause(rnd), 1'($urandom), 1'($urandom), 2'($urandom));
      end
    end
    bus.endr   = 1'b0;
    bus.pkt_in = 2'b00;
  endtask

  // Reset is held with pause high to show reset wins over pause.
  task automatic do_reset();
    bus.pkt_in = 2'b00;
    bus.endr   = 1'b0;
    rst_n = 1'b1;
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b0;
    tick(1'b0);
  endtask

  // Monitor: classifies each cycle by what the preceding edge saw, then compares.
  bit   mon_p, mon_r;
  bit   l_s, l_st, l_e;
  exp_t it;
  logic [1:0] ptyp;
  logic [15:0] resid;
  initial begin : monitor
    l_s = 1'b0; l_st = 1'b0; l_e = 1'b0;
    forever begin
      @(posedge clk);
      mon_p = bus.pause;
      mon_r = rst_n;
      @(negedge clk);
      if (mon_r) begin
        exp_q.delete();
        typ_q.delete();
        act_bits.delete();
        l_s = 1'b0; l_st = 1'b0; l_e = 1'b0;
        chk("rst_s_out",   32'(bus.s_out),   32'd0);
        chk("rst_start_b", 32'(bus.start_b), 32'd0);
        chk("rst_endb",    32'(bus.endb),    32'd0);
        chk("rst_state",   32'(dut.crc_cs),  32'(IDLE));
        chk("rst_crc5",    32'(dut.u_crc5.crc),  32'h1F);
        chk("rst_crc16",   32'(dut.u_crc16.crc), 32'hFFFF);
      end else if (mon_p) begin
        chk("hold_s_out",   32'(bus.s_out),   32'(l_s));
        chk("hold_start_b", 32'(bus.start_b), 32'(l_st));
        chk("hold_endb",    32'(bus.endb),    32'(l_e));
      end else if (bus.start_b || bus.endb) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(bus.start_b), 32'd0);
        end else begin
          it = exp_q.pop_front();
          chk("start_b", 32'(bus.start_b), 32'(!it.hs));
          chk("s_out",   32'(bus.s_out),   32'(it.b));
          chk("endb",    32'(bus.endb),    32'(it.last | it.hs));
          l_s = it.b; l_st = !it.hs; l_e = it.last | it.hs;
          if (!it.hs) act_bits.push_back(bus.s_out);
          if (it.last || it.hs) begin
            ptyp = (typ_q.size() != 0) ? typ_q.pop_front() : PKT_NONE;
            if (ptyp == PKT_TOKEN) begin
              resid = poly_rem(act_bits, 5, G5);
              chk("resid5", 32'(resid), 32'(RESID5));
            end else if (ptyp == PKT_DATA) begin
              resid = poly_rem(act_bits, 16, G16);
              chk("resid16", 32'(resid), 32'(RESID16));
            end
            act_bits.delete();
          end
        end
      end else begin
        chk("idle_s_out", 32'(bus.s_out), 32'd0);
        l_s = 1'b0; l_st = 1'b0; l_e = 1'b0;
      end
    end
  end

  initial begin : stim
    bit q[$];
    logic [1:0] t;
    int n;
    rst_n      = 1'b1;
    bus.pkt_in = 2'b00;
    bus.s_in   = 1'b0;
    bus.endr   = 1'b0;
    bus.pause  = 1'b0;
    do_reset();

    // TOKEN with addr=0, endp=0
    q = {};
    for (int i = 0; i < 11; i++) q.push_back(1'b0);
    send_pkt(PKT_TOKEN, q, -1, -1, 1'b0, -1);

    // zero-length DATA
    q = {};
    send_pkt(PKT_DATA, q, -1, -1, 1'b0, -1);

    // DATA 0x00, 0xFF LSB first; then the same with 3-cycle stalls in data and CRC
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(1'b1);
    send_pkt(PKT_DATA, q, -1, -1, 1'b0, -1);
    send_pkt(PKT_DATA, q, 5, 7, 1'b0, -1);

    // HANDSHAKE: bits pass through, no CRC
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(1'($urandom));
    send_pkt(PKT_HANDSHAKE, q, -1, -1, 1'b0, -1);

    // reset in the middle of SEND16, then a clean TOKEN
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(1'($urandom));
    send_pkt(PKT_DATA, q, -1, -1, 1'b0, 5);
    do_reset();
    q = {};
    for (int i = 0; i < 11; i++) q.push_back(1'($urandom));
    send_pkt(PKT_TOKEN, q, -1, -1, 1'b0, -1);

    // randomized packets with random stalls
    for (int p = 0; p < 40; p++) begin
      t = 2'($urandom_range(1, 3));
      n = (t == PKT_TOKEN) ? 11 : (t == PKT_DATA) ? int'($urandom_range(0, 24))
                                                  : int'($urandom_range(0, 8));
      q = {};
      for (int i = 0; i < n; i++) q.push_back(1'($urandom));
      send_pkt(t, q, -1, -1, 1'b1, -1);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("drain_exp", 32'(exp_q.size()), 32'd0);
    chk("drain_typ", 32'(typ_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
